// File: rtl/ysyx_22040127_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_22040127_mem_arbiter
//
// Purpose:
//   Shares a single memory port between the instruction fetch unit (IFU) and
//   the load/store unit (LSU). One transaction is in flight at a time. When
//   both units request together, the unit that did not win last time is
//   granted. The response is routed back to the unit that owns the
//   transaction. A watchdog aborts a transaction that stays too long in
//   ISSUE/WAIT and returns an error response instead.
//
// Ports:
//   clk, rst                     clock; asynchronous active-low reset
//   ifu_req_valid/ready, ifu_addr             IFU read request
//   ifu_resp_valid, ifu_rdata                 IFU response (one-cycle pulse)
//   lsu_req_valid/ready, lsu_addr, lsu_wen,
//   lsu_wdata, lsu_wmask                      LSU load/store request
//   lsu_resp_valid, lsu_rdata                 LSU response (one-cycle pulse)
//   resp_err                                  qualifies a response pulse as a timeout abort
//   mem_req_valid/ready, mem_addr, mem_wen,
//   mem_wdata, mem_wmask                      request to memory (fields latched)
//   mem_resp_valid, mem_rdata                 response from memory
// ---------------------------------------------------------------------------
module ysyx_22040127_mem_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 64,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_resp_valid,
   output logic [DATA_W-1:0]   ifu_rdata,

   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_resp_valid,
   output logic [DATA_W-1:0]   lsu_rdata,

   output logic                resp_err,

   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_resp_valid,
   input  logic [DATA_W-1:0]   mem_rdata
);

   // The watchdog counter only ever has to reach TIMEOUT_CYC-1.
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_t;

   state_t           state;
   state_t           state_next;
   owner_t           owner;
   owner_t           last_grant;
   logic [CNT_W-1:0] counter;

   logic grant_ifu;
   logic grant_lsu;
   logic complete;
   logic abort;
   logic expired;

   // The watchdog fires on the last allowed cycle; a zero limit disables it.
   assign expired = (TIMEOUT_CYC > 0) && (counter == CNT_W'(TIMEOUT_CYC - 1));

   // Readies are forced low while reset is asserted so that every output
   // reads zero during reset even if a requester holds its valid high.
   assign ifu_req_ready = grant_ifu && rst;
   assign lsu_req_ready = grant_lsu && rst;
   assign mem_req_valid = (state == S_ISSUE);

   // Next-state logic and arbitration. In IDLE the LSU wins a tie unless it
   // was the previous winner, which gives strict alternation under constant
   // contention. In ISSUE an expiry takes precedence over memory accepting
   // the request; in WAIT a response takes precedence over an expiry.
   always_comb begin
      state_next = state;
      grant_ifu  = 1'b0;
      grant_lsu  = 1'b0;
      complete   = 1'b0;
      abort      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (lsu_req_valid && (!ifu_req_valid || last_grant == OWN_IFU)) begin
               grant_lsu = 1'b1;
            end else if (ifu_req_valid) begin
               grant_ifu = 1'b1;
            end
            if (grant_lsu || grant_ifu) begin
               state_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (expired) begin
               abort      = 1'b1;
               state_next = S_IDLE;
            end else if (mem_req_ready) begin
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_resp_valid) begin
               complete   = 1'b1;
               state_next = S_IDLE;
            end else if (expired) begin
               abort      = 1'b1;
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // State register, request latching, watchdog counter and response
   // generation. Response pulses and resp_err default low every cycle; the
   // rdata registers are only written when their owner receives a response,
   // so they hold their value between pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= S_IDLE;
         owner          <= OWN_IFU;
         last_grant     <= OWN_IFU;
         counter        <= '0;
         mem_addr       <= '0;
         mem_wen        <= 1'b0;
         mem_wdata      <= '0;
         mem_wmask      <= '0;
         ifu_resp_valid <= 1'b0;
         lsu_resp_valid <= 1'b0;
         ifu_rdata      <= '0;
         lsu_rdata      <= '0;
         resp_err       <= 1'b0;
      end else begin
         state          <= state_next;
         ifu_resp_valid <= 1'b0;
         lsu_resp_valid <= 1'b0;
         resp_err       <= 1'b0;

         if (grant_lsu) begin
            owner      <= OWN_LSU;
            last_grant <= OWN_LSU;
            counter    <= '0;
            mem_addr   <= lsu_addr;
            mem_wen    <= lsu_wen;
            mem_wdata  <= lsu_wdata;
            mem_wmask  <= lsu_wmask;
         end else if (grant_ifu) begin
            owner      <= OWN_IFU;
            last_grant <= OWN_IFU;
            counter    <= '0;
            mem_addr   <= ifu_addr;
            mem_wen    <= 1'b0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
         end else if (state != S_IDLE && TIMEOUT_CYC > 0) begin
            counter <= counter + CNT_W'(1);
         end

         // An abort returns zero data with the error flag set.
         if (complete || abort) begin
            resp_err <= abort;
            if (owner == OWN_LSU) begin
               lsu_resp_valid <= 1'b1;
               lsu_rdata      <= abort ? '0 : mem_rdata;
            end else begin
               ifu_resp_valid <= 1'b1;
               ifu_rdata      <= abort ? '0 : mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22040127_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22040127_mem_arbiter
//
// Directed bench for the IFU/LSU memory arbiter. The bench plays the part of
// both requesters and of the memory. Whenever a request is granted, the
// response the requester should later receive is pushed onto a scoreboard
// queue; when a response pulse appears it is popped and compared.
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled 1 time unit after that.
// ---------------------------------------------------------------------------
module tb_ysyx_22040127_mem_arbiter;

   localparam int ADDR_W      = 32;
   localparam int DATA_W      = 64;
   localparam int TIMEOUT_CYC = 8;

   logic                clk = 1'b0;
   logic                rst;
   logic                ifu_req_valid;
   logic                ifu_req_ready;
   logic [ADDR_W-1:0]   ifu_addr;
   logic                ifu_resp_valid;
   logic [DATA_W-1:0]   ifu_rdata;
   logic                lsu_req_valid;
   logic                lsu_req_ready;
   logic [ADDR_W-1:0]   lsu_addr;
   logic                lsu_wen;
   logic [DATA_W-1:0]   lsu_wdata;
   logic [DATA_W/8-1:0] lsu_wmask;
   logic                lsu_resp_valid;
   logic [DATA_W-1:0]   lsu_rdata;
   logic                resp_err;
   logic                mem_req_valid;
   logic                mem_req_ready;
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_wen;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W/8-1:0] mem_wmask;
   logic                mem_resp_valid;
   logic [DATA_W-1:0]   mem_rdata;

   // pulse is {lsu_resp_valid, ifu_resp_valid} expected on the response cycle.
   typedef struct packed {
      logic [1:0]  pulse;
      logic [63:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   ysyx_22040127_mem_arbiter #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ifu_req_valid  (ifu_req_valid),
      .ifu_req_ready  (ifu_req_ready),
      .ifu_addr       (ifu_addr),
      .ifu_resp_valid (ifu_resp_valid),
      .ifu_rdata      (ifu_rdata),
      .lsu_req_valid  (lsu_req_valid),
      .lsu_req_ready  (lsu_req_ready),
      .lsu_addr       (lsu_addr),
      .lsu_wen        (lsu_wen),
      .lsu_wdata      (lsu_wdata),
      .lsu_wmask      (lsu_wmask),
      .lsu_resp_valid (lsu_resp_valid),
      .lsu_rdata      (lsu_rdata),
      .resp_err       (resp_err),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_addr       (mem_addr),
      .mem_wen        (mem_wen),
      .mem_wdata      (mem_wdata),
      .mem_wmask      (mem_wmask),
      .mem_resp_valid (mem_resp_valid),
      .mem_rdata      (mem_rdata)
   );

   always #5 clk = ~clk;

   // Hard stop in case a wait in the sequence never finishes.
   initial begin
      #100000;
      $display("[TB] FAIL global_timeout observed=running expected=finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic ifu_v, input logic [31:0] i_addr,
                                input logic lsu_v, input logic [31:0] l_addr,
                                input logic wen, input logic [63:0] wdata,
                                input logic [7:0] wmask);
      ifu_req_valid = ifu_v;
      ifu_addr      = i_addr;
      lsu_req_valid = lsu_v;
      lsu_addr      = l_addr;
      lsu_wen       = wen;
      lsu_wdata     = wdata;
      lsu_wmask     = wmask;
   endtask

   // Every output must read zero (used during reset).
   task automatic checkQuiet(input string tag);
      checkOutput({tag, "_readies"}, 64'({lsu_req_ready, ifu_req_ready}), 64'd0);
      checkOutput({tag, "_pulses"},  64'({lsu_resp_valid, ifu_resp_valid}), 64'd0);
      checkOutput({tag, "_err"},     64'(resp_err), 64'd0);
      checkOutput({tag, "_mreq"},    64'(mem_req_valid), 64'd0);
      checkOutput({tag, "_maddr"},   64'(mem_addr), 64'd0);
      checkOutput({tag, "_mwen"},    64'(mem_wen), 64'd0);
      checkOutput({tag, "_mwdata"},  mem_wdata, 64'd0);
      checkOutput({tag, "_mwmask"},  64'(mem_wmask), 64'd0);
      checkOutput({tag, "_irdata"},  ifu_rdata, 64'd0);
      checkOutput({tag, "_lrdata"},  lsu_rdata, 64'd0);
   endtask

   // Acts as memory from the first ISSUE cycle: holds ready low for
   // ready_delay cycles, then waits resp_delay cycles in WAIT before
   // responding with rdata. Returns at the cycle where the response pulse
   // is due. Optionally drives a bogus response during ISSUE, which the
   // arbiter has to ignore.
   task automatic memService(input logic [31:0] e_addr, input logic e_wen,
                             input logic [63:0] e_wdata, input logic [7:0] e_wmask,
                             input int ready_delay, input int resp_delay,
                             input logic [63:0] rdata, input logic junk_in_issue);
      for (int i = 0; i <= ready_delay; i++) begin
         mem_req_ready  = (i == ready_delay);
         mem_resp_valid = junk_in_issue;
         mem_rdata      = 64'hBAD0_BAD0_BAD0_BAD0;
         #1;
         checkOutput("issue_valid", 64'(mem_req_valid), 64'd1);
         checkOutput("issue_addr", 64'(mem_addr), 64'(e_addr));
         checkOutput("issue_wen", 64'(mem_wen), 64'(e_wen));
         checkOutput("issue_wmask", 64'(mem_wmask), 64'(e_wmask));
         if (e_wen) checkOutput("issue_wdata", mem_wdata, e_wdata);
         checkOutput("issue_readies", 64'({lsu_req_ready, ifu_req_ready}), 64'd0);
         checkOutput("issue_no_pulse", 64'({lsu_resp_valid, ifu_resp_valid}), 64'd0);
         nextCycle();
      end
      mem_req_ready = 1'b0;
      for (int i = 0; i <= resp_delay; i++) begin
         mem_resp_valid = (i == resp_delay);
         mem_rdata      = (i == resp_delay) ? rdata : 64'h5A5A_5A5A_5A5A_5A5A;
         #1;
         checkOutput("wait_no_req", 64'(mem_req_valid), 64'd0);
         checkOutput("wait_no_pulse", 64'({lsu_resp_valid, ifu_resp_valid}), 64'd0);
         nextCycle();
      end
      mem_resp_valid = 1'b0;
   endtask

   // Waits (bounded) for a response pulse and compares it with the oldest
   // scoreboard entry, including how many cycles it took to appear.
   task automatic checkResp(input string tag, input int exp_wait);
      int   waited;
      exp_t e;
      waited = 0;
      while (!(ifu_resp_valid || lsu_resp_valid) && waited < 20) begin
         nextCycle();
         waited++;
      end
      checkOutput({tag, "_seen"}, 64'(ifu_resp_valid || lsu_resp_valid), 64'd1);
      checkOutput({tag, "_latency"}, 64'(waited), 64'(exp_wait));
      checkOutput({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput({tag, "_pulse"}, 64'({lsu_resp_valid, ifu_resp_valid}), 64'(e.pulse));
         checkOutput({tag, "_rdata"}, e.pulse[1] ? lsu_rdata : ifu_rdata, e.rdata);
         checkOutput({tag, "_err"}, 64'(resp_err), 64'(e.err));
      end
   endtask

   // Directed sequence of steps.
   initial begin
      logic [63:0] data;
      logic        exp_lsu;

      rst            = 1'b0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_rdata      = '0;
      applyStimulus(1'b1, 32'h8000_0000, 1'b1, 32'h8000_1000, 1'b0, '0, '0);
      nextCycle();
      nextCycle();
      checkQuiet("reset");
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
      rst = 1'b1;
      nextCycle();

      // IFU read at minimum latency.
      $display("[TB] IFU read, minimum latency");
      data = 64'h0010_0073_0000_0413;
      applyStimulus(1'b1, 32'h8000_0000, 1'b0, '0, 1'b0, '0, '0);
      #1;
      checkOutput("t2_grant", 64'({lsu_req_ready, ifu_req_ready}), 64'b01);
      sb.push_back('{pulse: 2'b01, rdata: data, err: 1'b0});
      nextCycle();
      applyStimulus(1'b0, 32'h1234_5678, 1'b0, '0, 1'b0, '0, '0);
      memService(32'h8000_0000, 1'b0, '0, 8'h00, 0, 0, data, 1'b0);
      checkResp("t2_resp", 0);
      nextCycle();
      checkOutput("t2_pulse_once", 64'({lsu_resp_valid, ifu_resp_valid}), 64'd0);
      checkOutput("t2_rdata_hold", ifu_rdata, data);

      // LSU load interrupted by reset while waiting for memory.
      $display("[TB] reset during WAIT");
      applyStimulus(1'b0, '0, 1'b1, 32'h8000_0100, 1'b0, '0, '0);
      #1;
      checkOutput("t1_grant", 64'({lsu_req_ready, ifu_req_ready}), 64'b10);
      nextCycle();
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
      mem_req_ready = 1'b1;
      nextCycle();
      mem_req_ready = 1'b0;
      #1;
      checkOutput("t1_in_wait", 64'(mem_req_valid), 64'd0);
      rst = 1'b0;
      #1;
      checkQuiet("t1_async");
      mem_resp_valid = 1'b1;
      mem_rdata      = 64'hFFFF_0000_FFFF_0000;
      nextCycle();
      checkQuiet("t1_held");
      rst = 1'b1;
      nextCycle();
      mem_resp_valid = 1'b0;
      #1;
      checkOutput("t1_dropped", 64'({lsu_resp_valid, ifu_resp_valid}), 64'd0);

      // Constant contention: grants must alternate starting with the LSU.
      $display("[TB] fair arbitration");
      applyStimulus(1'b1, 32'h8000_0200, 1'b1, 32'h8000_2000, 1'b0, '0, '0);
      for (int k = 0; k < 4; k++) begin
         exp_lsu = (k % 2 == 0);
         data    = 64'h1111_0000_0000_0000 + 64'(k);
         #1;
         checkOutput("t3_grant", 64'({lsu_req_ready, ifu_req_ready}),
                     exp_lsu ? 64'b10 : 64'b01);
         sb.push_back('{pulse: exp_lsu ? 2'b10 : 2'b01, rdata: data, err: 1'b0});
         nextCycle();
         memService(exp_lsu ? 32'h8000_2000 : 32'h8000_0200, 1'b0, '0, 8'h00,
                    0, 0, data, 1'b0);
         checkResp("t3_resp", 0);
      end
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
      nextCycle();

      // LSU store with memory stalling the request; fields must hold.
      $display("[TB] stalled LSU store");
      applyStimulus(1'b0, '0, 1'b1, 32'h8000_1008, 1'b1, 64'hDEAD_BEEF, 8'h0F);
      #1;
      checkOutput("t4_grant", 64'({lsu_req_ready, ifu_req_ready}), 64'b10);
      sb.push_back('{pulse: 2'b10, rdata: 64'h1234, err: 1'b0});
      nextCycle();
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
      memService(32'h8000_1008, 1'b1, 64'hDEAD_BEEF, 8'h0F, 5, 0, 64'h1234, 1'b1);
      checkResp("t4_resp", 0);

      // Memory never answers: abort after TIMEOUT_CYC cycles in ISSUE/WAIT.
      $display("[TB] watchdog abort");
      applyStimulus(1'b0, '0, 1'b1, 32'h8000_3000, 1'b0, '0, '0);
      #1;
      checkOutput("t5_grant", 64'({lsu_req_ready, ifu_req_ready}), 64'b10);
      sb.push_back('{pulse: 2'b10, rdata: 64'd0, err: 1'b1});
      nextCycle();
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
      mem_req_ready = 1'b1;
      #1;
      checkOutput("t5_issue", 64'(mem_req_valid), 64'd1);
      nextCycle();
      mem_req_ready = 1'b0;
      checkResp("t5_resp", TIMEOUT_CYC - 1);
      mem_resp_valid = 1'b1;
      mem_rdata      = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int k = 0; k < 2; k++) begin
         nextCycle();
         checkOutput("t5_late_no_pulse", 64'({lsu_resp_valid, ifu_resp_valid}), 64'd0);
         checkOutput("t5_err_clear", 64'(resp_err), 64'd0);
         checkOutput("t5_idle", 64'(mem_req_valid), 64'd0);
         checkOutput("t5_rdata_hold", lsu_rdata, 64'd0);
      end
      mem_resp_valid = 1'b0;
      nextCycle();

      // Response arrives on the very cycle the watchdog expires.
      $display("[TB] completion at expiry");
      data = 64'hCAFE_F00D_0BAD_BEEF;
      applyStimulus(1'b1, 32'h8000_4000, 1'b0, '0, 1'b0, '0, '0);
      #1;
      checkOutput("t6_grant", 64'({lsu_req_ready, ifu_req_ready}), 64'b01);
      sb.push_back('{pulse: 2'b01, rdata: data, err: 1'b0});
      nextCycle();
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
      memService(32'h8000_4000, 1'b0, '0, 8'h00, 0, TIMEOUT_CYC - 2, data, 1'b0);
      checkResp("t6_resp", 0);

      nextCycle();
      checkOutput("sb_drained", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
